// File: rtl/layer_readout_scheduler_pkg.sv
// Shared definitions for the layer readout scheduler: FSM states and default sizing.
package astep_sched_pkg;

    localparam int unsigned SCHED_NLAYERS    = 20;
    localparam int unsigned SCHED_HOLD_SETUP = 4;
    localparam int unsigned SCHED_TIMEOUT    = 65535;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        READ,
        RELEASE
    } sched_state_e;

endpackage

// File: rtl/layer_readout_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after the pointer, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int unsigned N = 20,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    int unsigned  pos;
    logic [W-1:0] pos_w;

    // Offset N wraps back onto the pointer itself, so it is the lowest-priority candidate.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_w   = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            pos = 32'(ptr_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_w = W'(pos);
            if (!valid_o && req_i[pos_w]) begin
                valid_o = 1'b1;
                idx_o   = pos_w;
            end
        end
    end

endmodule

// File: rtl/layer_readout_scheduler.sv
// Shares one SPI readout engine among the detector layers: synchronises interrupts,
// grants hold round-robin, requests the readout and releases on completion or timeout.
module layer_readout_scheduler
    import astep_sched_pkg::*;
#(
    parameter int unsigned NLAYERS    = SCHED_NLAYERS,
    parameter int unsigned LW         = $clog2(NLAYERS),
    parameter int unsigned HOLD_SETUP = SCHED_HOLD_SETUP,
    parameter int unsigned TIMEOUT    = SCHED_TIMEOUT
) (
    input  logic               sysclk,
    input  logic               warm_resn,
    input  logic               enable,
    input  logic [NLAYERS-1:0] layer_mask,
    input  logic [NLAYERS-1:0] layer_interruptn,
    output logic [NLAYERS-1:0] layer_hold,
    output logic               rd_req,
    output logic [LW-1:0]      rd_layer,
    input  logic               rd_done,
    output logic               busy,
    output logic               timeout_pulse,
    output logic [15:0]        timeout_count
);

    localparam int unsigned CNT_MAX = (TIMEOUT > HOLD_SETUP) ? TIMEOUT : HOLD_SETUP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    logic [NLAYERS-1:0] sync1_q;
    logic [NLAYERS-1:0] sync2_q;
    logic [NLAYERS-1:0] pending;
    logic               arb_valid;
    logic [LW-1:0]      arb_idx;

    sched_state_e       state_q;
    logic [NLAYERS-1:0] hold_q;
    logic               req_q;
    logic [LW-1:0]      layer_q;
    logic [LW-1:0]      last_q;
    logic               busy_q;
    logic               tpulse_q;
    logic [15:0]        tcount_q;
    logic [CW-1:0]      cnt_q;

    always_ff @(posedge sysclk or negedge warm_resn) begin
        if (!warm_resn) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= layer_interruptn;
            sync2_q <= sync1_q;
        end
    end

    assign pending = ~sync2_q & layer_mask;

    rr_arbiter #(
        .N (NLAYERS),
        .W (LW)
    ) u_arb (
        .req_i   (pending),
        .ptr_i   (last_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    always_ff @(posedge sysclk or negedge warm_resn) begin
        if (!warm_resn) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            req_q    <= 1'b0;
            layer_q  <= '0;
            last_q   <= LW'(NLAYERS - 1);
            busy_q   <= 1'b0;
            tpulse_q <= 1'b0;
            tcount_q <= '0;
            cnt_q    <= '0;
        end else begin
            tpulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && arb_valid) begin
                        layer_q <= arb_idx;
                        hold_q  <= NLAYERS'(1) << arb_idx;
                        cnt_q   <= CW'(HOLD_SETUP - 1);
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        req_q   <= 1'b1;
                        cnt_q   <= CW'(TIMEOUT - 1);
                        state_q <= READ;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READ: begin
                    // Completion takes precedence over a coincident counter expiry.
                    if (rd_done) begin
                        req_q   <= 1'b0;
                        hold_q  <= '0;
                        state_q <= RELEASE;
                    end else if (cnt_q == '0) begin
                        tpulse_q <= 1'b1;
                        if (tcount_q != 16'hFFFF) begin
                            tcount_q <= tcount_q + 16'd1;
                        end
                        req_q   <= 1'b0;
                        hold_q  <= '0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    last_q  <= layer_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign layer_hold    = hold_q;
    assign rd_req        = req_q;
    assign rd_layer      = layer_q;
    assign busy          = busy_q;
    assign timeout_pulse = tpulse_q;
    assign timeout_count = tcount_q;

endmodule

// File: tb/tb_layer_readout_scheduler.sv
// Self-checking bench for layer_readout_scheduler: directed scenarios plus a randomized
// round-robin run against a distance-based arbitration model.
module tb_layer_readout_scheduler;

    localparam int NL = 20;
    localparam int LW = 5;
    localparam int HS = 4;
    localparam int TO = 100;

    logic          sysclk    = 1'b0;
    logic          warm_resn = 1'b1;
    logic          enable    = 1'b1;
    logic [NL-1:0] mask      = '1;
    logic [NL-1:0] intn      = '1;
    logic          rd_done   = 1'b0;
    logic [NL-1:0] layer_hold;
    logic          rd_req;
    logic [LW-1:0] rd_layer;
    logic          busy;
    logic          timeout_pulse;
    logic [15:0]   timeout_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    layer_readout_scheduler #(
        .NLAYERS    (NL),
        .HOLD_SETUP (HS),
        .TIMEOUT    (TO)
    ) dut (
        .sysclk           (sysclk),
        .warm_resn        (warm_resn),
        .enable           (enable),
        .layer_mask       (mask),
        .layer_interruptn (intn),
        .layer_hold       (layer_hold),
        .rd_req           (rd_req),
        .rd_layer         (rd_layer),
        .rd_done          (rd_done),
        .busy             (busy),
        .timeout_pulse    (timeout_pulse),
        .timeout_count    (timeout_count)
    );

    // Winner = pending layer at the smallest forward distance after the last grant.
    function automatic int model_pick(input logic [NL-1:0] pend, input int last);
        int best  = -1;
        int bestd = NL + 1;
        for (int l = 0; l < NL; l++) begin
            if (pend[l]) begin
                int d = (l - last - 1 + 2 * NL) % NL;
                if (d < bestd) begin
                    bestd = d;
                    best  = l;
                end
            end
        end
        return best;
    endfunction

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic apply_reset();
        warm_resn = 1'b0;
        enable    = 1'b1;
        mask      = '1;
        intn      = '1;
        rd_done   = 1'b0;
        tick();
        tick();
        warm_resn = 1'b1;
        tick();
    endtask

    task automatic wait_hold(input int limit, output int waited);
        waited = 0;
        while (layer_hold === '0 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic wait_req(input int limit, output int waited);
        waited = 0;
        while (rd_req !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int w = 0;
        while (busy !== 1'b0 && w < limit) begin
            tick();
            w++;
        end
    endtask

    task automatic finish_readout();
        int w;
        wait_req(TO + 20, w);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        wait_idle(20);
    endtask

    task automatic test_reset();
        tick();
        warm_resn = 1'b0;
        #1;
        n_checks++;
        if (layer_hold !== '0) begin n_fail++; $display("FAIL reset_hold: got %h expected 0", layer_hold); end
        n_checks++;
        if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", rd_req); end
        n_checks++;
        if (rd_layer !== '0) begin n_fail++; $display("FAIL reset_layer: got %0d expected 0", rd_layer); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_tpulse: got %b expected 0", timeout_pulse); end
        n_checks++;
        if (timeout_count !== 16'd0) begin n_fail++; $display("FAIL reset_tcount: got %0d expected 0", timeout_count); end
        tick();
        warm_resn = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({busy, layer_hold} !== '0) begin n_fail++; $display("FAIL reset_quiet: got busy=%b hold=%h expected 0/0", busy, layer_hold); end
    endtask

    task automatic test_single();
        logic [NL-1:0] exp_hold;
        logic          exp_req;
        logic          exp_busy;
        apply_reset();
        intn[5] = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            exp_hold = (c >= 3 && c <= 10) ? NL'(1) << 5 : '0;
            exp_req  = (c >= 7 && c <= 10);
            exp_busy = (c >= 3 && c <= 11);
            n_checks++;
            if (layer_hold !== exp_hold) begin n_fail++; $display("FAIL single_hold c=%0d: got %h expected %h", c, layer_hold, exp_hold); end
            n_checks++;
            if (rd_req !== exp_req) begin n_fail++; $display("FAIL single_req c=%0d: got %b expected %b", c, rd_req, exp_req); end
            n_checks++;
            if (busy !== exp_busy) begin n_fail++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
            if (c == 7) begin
                n_checks++;
                if (rd_layer !== LW'(5)) begin n_fail++; $display("FAIL single_layer: got %0d expected 5", rd_layer); end
                intn[5] = 1'b1;
            end
            rd_done = (c == 5) || (c == 10);
        end
    endtask

    task automatic test_round_robin();
        int seq [5];
        int w;
        seq = '{0, 3, 19, 0, 3};
        apply_reset();
        intn[0]  = 1'b0;
        intn[3]  = 1'b0;
        intn[19] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_hold(20, w);
            if (i > 0) begin
                n_checks++;
                if (w !== 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d cycles expected 2", i, w); end
            end
            n_checks++;
            if (layer_hold !== NL'(1) << seq[i]) begin n_fail++; $display("FAIL rr_hold[%0d]: got %h expected %h", i, layer_hold, NL'(1) << seq[i]); end
            n_checks++;
            if (rd_layer !== LW'(seq[i])) begin n_fail++; $display("FAIL rr_layer[%0d]: got %0d expected %0d", i, rd_layer, seq[i]); end
            wait_req(20, w);
            n_checks++;
            if (w !== HS) begin n_fail++; $display("FAIL rr_setup[%0d]: got %0d cycles expected %0d", i, w, HS); end
            if (i == 4) intn = '1;
            rd_done = 1'b1;
            tick();
            rd_done = 1'b0;
            n_checks++;
            if ({rd_req, layer_hold} !== '0) begin n_fail++; $display("FAIL rr_release[%0d]: got req=%b hold=%h expected 0/0", i, rd_req, layer_hold); end
        end
        repeat (6) tick();
        n_checks++;
        if ({busy, layer_hold} !== '0) begin n_fail++; $display("FAIL rr_idle: got busy=%b hold=%h expected 0/0", busy, layer_hold); end
    endtask

    task automatic test_mask();
        int w;
        apply_reset();
        mask[7] = 1'b0;
        intn[7] = 1'b0;
        repeat (8) tick();
        n_checks++;
        if ({busy, layer_hold} !== '0) begin n_fail++; $display("FAIL mask_block: got busy=%b hold=%h expected 0/0", busy, layer_hold); end
        mask[7] = 1'b1;
        tick();
        n_checks++;
        if (layer_hold !== NL'(1) << 7) begin n_fail++; $display("FAIL mask_grant: got %h expected %h", layer_hold, NL'(1) << 7); end
        mask[7] = 1'b0;
        wait_req(10, w);
        n_checks++;
        if ({rd_req, layer_hold, rd_layer} !== {1'b1, NL'(1) << 7, LW'(7)}) begin
            n_fail++; $display("FAIL mask_no_abort: got req=%b hold=%h layer=%0d expected 1/%h/7", rd_req, layer_hold, rd_layer, NL'(1) << 7);
        end
        intn[7] = 1'b1;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        wait_idle(10);
        mask = '1;
    endtask

    task automatic test_timeout();
        int hi;
        int pulses;
        int w;
        apply_reset();
        intn[2] = 1'b0;
        wait_req(20, w);
        hi     = 0;
        pulses = 0;
        while (rd_req === 1'b1 && hi < TO + 20) begin
            hi++;
            tick();
            if (timeout_pulse === 1'b1) pulses++;
        end
        repeat (2) begin
            tick();
            if (timeout_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (hi !== TO) begin n_fail++; $display("FAIL to_req_len: got %0d cycles expected %0d", hi, TO); end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
        n_checks++;
        if (timeout_count !== 16'd1) begin n_fail++; $display("FAIL to_count: got %0d expected 1", timeout_count); end
        wait_hold(10, w);
        n_checks++;
        if ({layer_hold, rd_layer} !== {NL'(1) << 2, LW'(2)}) begin n_fail++; $display("FAIL to_regrant: got hold=%h layer=%0d expected %h/2", layer_hold, rd_layer, NL'(1) << 2); end
        intn[2] = 1'b1;
        finish_readout();
    endtask

    task automatic test_expiry_boundary();
        int w;
        apply_reset();
        intn[9] = 1'b0;
        wait_req(20, w);
        intn[9] = 1'b1;
        repeat (TO - 1) tick();
        n_checks++;
        if (rd_req !== 1'b1) begin n_fail++; $display("FAIL edge_last_read: got req=%b expected 1", rd_req); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++;
        if ({rd_req, timeout_pulse} !== 2'b00) begin n_fail++; $display("FAIL edge_done: got req=%b pulse=%b expected 0/0", rd_req, timeout_pulse); end
        repeat (3) tick();
        n_checks++;
        if (timeout_count !== 16'd0) begin n_fail++; $display("FAIL edge_count: got %0d expected 0", timeout_count); end
    endtask

    task automatic test_enable_drop();
        int w;
        apply_reset();
        intn[4] = 1'b0;
        wait_req(20, w);
        enable = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({rd_req, layer_hold} !== {1'b1, NL'(1) << 4}) begin n_fail++; $display("FAIL en_no_abort: got req=%b hold=%h expected 1/%h", rd_req, layer_hold, NL'(1) << 4); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        n_checks++;
        if ({rd_req, layer_hold} !== '0) begin n_fail++; $display("FAIL en_release: got req=%b hold=%h expected 0/0", rd_req, layer_hold); end
        repeat (10) tick();
        n_checks++;
        if ({busy, layer_hold} !== '0) begin n_fail++; $display("FAIL en_parked: got busy=%b hold=%h expected 0/0", busy, layer_hold); end
        enable = 1'b1;
        wait_hold(10, w);
        n_checks++;
        if (layer_hold !== NL'(1) << 4) begin n_fail++; $display("FAIL en_resume: got %h expected %h", layer_hold, NL'(1) << 4); end
        intn[4] = 1'b1;
        finish_readout();
    endtask

    task automatic test_reset_mid_read();
        int w;
        apply_reset();
        intn[12] = 1'b0;
        wait_req(20, w);
        n_checks++;
        if (rd_layer !== LW'(12)) begin n_fail++; $display("FAIL rst_pre_layer: got %0d expected 12", rd_layer); end
        intn[0] = 1'b0;
        repeat (3) tick();
        #2;
        warm_resn = 1'b0;
        #1;
        n_checks++;
        if ({layer_hold, rd_req} !== '0) begin n_fail++; $display("FAIL rst_async_out: got hold=%h req=%b expected 0/0", layer_hold, rd_req); end
        n_checks++;
        if ({rd_layer, busy, timeout_pulse} !== '0) begin n_fail++; $display("FAIL rst_async_state: got layer=%0d busy=%b pulse=%b expected 0/0/0", rd_layer, busy, timeout_pulse); end
        tick();
        warm_resn = 1'b1;
        wait_hold(10, w);
        n_checks++;
        if (layer_hold !== NL'(1) << 0) begin n_fail++; $display("FAIL rst_first: got %h expected %h", layer_hold, NL'(1) << 0); end
        wait_req(20, w);
        intn[0]  = 1'b1;
        rd_done  = 1'b1;
        tick();
        rd_done = 1'b0;
        wait_hold(10, w);
        n_checks++;
        if (layer_hold !== NL'(1) << 12) begin n_fail++; $display("FAIL rst_second: got %h expected %h", layer_hold, NL'(1) << 12); end
        intn[12] = 1'b1;
        finish_readout();
    endtask

    task automatic test_random();
        int            last = NL - 1;
        int            tcnt = 0;
        int            exp;
        int            w;
        int            b;
        logic [NL-1:0] pend;
        apply_reset();
        b       = $urandom_range(0, NL - 1);
        intn    = NL'($urandom);
        mask    = NL'($urandom);
        intn[b] = 1'b0;
        mask[b] = 1'b1;
        for (int it = 0; it < 40; it++) begin
            pend = ~intn & mask;
            exp  = model_pick(pend, last);
            wait_hold(30, w);
            n_checks++;
            if ({layer_hold, rd_layer} !== {NL'(1) << exp, LW'(exp)}) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got hold=%h layer=%0d expected %h/%0d", it, layer_hold, rd_layer, NL'(1) << exp, exp);
            end
            wait_req(30, w);
            n_checks++;
            if (w !== HS) begin n_fail++; $display("FAIL rand_setup[%0d]: got %0d cycles expected %0d", it, w, HS); end
            b       = $urandom_range(0, NL - 1);
            intn    = NL'($urandom);
            mask    = NL'($urandom);
            intn[b] = 1'b0;
            mask[b] = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                w = 0;
                while (rd_req === 1'b1 && w < TO + 20) begin
                    tick();
                    w++;
                end
                tcnt++;
                n_checks++;
                if (w !== TO) begin n_fail++; $display("FAIL rand_to_len[%0d]: got %0d cycles expected %0d", it, w, TO); end
            end else begin
                repeat ($urandom_range(0, 12)) tick();
                rd_done = 1'b1;
                tick();
                rd_done = 1'b0;
            end
            n_checks++;
            if (timeout_count !== 16'(tcnt)) begin n_fail++; $display("FAIL rand_tcount[%0d]: got %0d expected %0d", it, timeout_count, tcnt); end
            last = exp;
        end
        intn = '1;
        wait_idle(TO + 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_timeout();
        test_expiry_boundary();
        test_enable_drop();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
